// File: rtl/seq_restoring_div_16_8_pkg.sv
// Shared constants and types for the 16/8 restoring divider.
package div_pkg;

    localparam int W_N   = 16;
    localparam int W_D   = 8;
    localparam int STEPS = 16;
    localparam int CNT_W = 4;

    localparam logic [W_N-1:0]   DZ_QUOTIENT = 16'hFFFF;
    localparam logic [CNT_W-1:0] LAST_STEP   = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_restoring_div_16_8_if.sv
// Operand/result valid-ready bundle; master is the requester, slave the divider.
interface seq_restoring_div_16_8_if;
    import div_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [W_N-1:0] IN1;
    logic [W_D-1:0] IN2;
    logic           out_valid;
    logic           out_ready;
    logic [W_N-1:0] Q;
    logic [W_D-1:0] R;
    logic           dz;

    modport master (
        output in_valid, IN1, IN2, out_ready,
        input  in_ready, out_valid, Q, R, dz
    );

    modport slave (
        input  in_valid, IN1, IN2, out_ready,
        output in_ready, out_valid, Q, R, dz
    );

endinterface

// File: rtl/seq_restoring_div_16_8_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module div_restore_step
    import div_pkg::*;
(
    input  logic [W_D:0]   r_i,
    input  logic [W_N-1:0] q_i,
    input  logic [W_D-1:0] d_i,
    output logic [W_D:0]   r_o,
    output logic [W_N-1:0] q_o
);

    logic [W_D:0] t;
    logic [W_D:0] d_ext;
    logic         unused_r_msb;

    // r[8] is always 0 between steps, so only r[7:0] feeds the shift.
    assign unused_r_msb = r_i[W_D];
    assign t            = {r_i[W_D-1:0], q_i[W_N-1]};
    assign d_ext        = {1'b0, d_i};

    always_comb begin
        if (t >= d_ext) begin
            r_o = t - d_ext;
            q_o = {q_i[W_N-2:0], 1'b1};
        end else begin
            r_o = t;
            q_o = {q_i[W_N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_restoring_div_16_8.sv
// Sequential radix-2 restoring divider, 16-bit dividend / 8-bit divisor,
// one operation in flight, valid/ready on both sides.
module seq_restoring_div_16_8
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    seq_restoring_div_16_8_if.slave bus
);

    div_state_t       state_q, state_d;
    logic [W_N-1:0]   q_q, q_d;
    logic [W_D-1:0]   d_q, d_d;
    logic [W_D:0]     r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W_N-1:0]   qo_q, qo_d;
    logic [W_D-1:0]   ro_q, ro_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;

    logic [W_D:0]     step_r;
    logic [W_N-1:0]   step_q;

    div_restore_step u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    always_ff @(posedge clk) begin
        // NOTE: state uses <= so every flop samples the pre-edge values of its _d.
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            qo_q    <= '0;
            ro_q    <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            qo_q    <= qo_d;
            ro_q    <= ro_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = (bus.IN2 == '0) ? DONE : CALC;
            CALC:    if (cnt_q == LAST_STEP) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        q_d   = q_q;
        d_d   = d_q;
        r_d   = r_q;
        cnt_d = cnt_q;
        qo_d  = qo_q;
        ro_d  = ro_q;
        dz_d  = dz_q;
        ov_d  = ov_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    q_d   = bus.IN1;
                    d_d   = bus.IN2;
                    r_d   = '0;
                    cnt_d = '0;
                    // A zero divisor skips the iterations and reports straight away.
                    if (bus.IN2 == '0) begin
                        qo_d = DZ_QUOTIENT;
                        ro_d = bus.IN1[W_D-1:0];
                        dz_d = 1'b1;
                        ov_d = 1'b1;
                    end
                end
            end
            CALC: begin
                q_d   = step_q;
                r_d   = step_r;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    qo_d = step_q;
                    ro_d = step_r[W_D-1:0];
                    dz_d = 1'b0;
                    ov_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) ov_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE);
    end

    assign bus.out_valid = ov_q;
    assign bus.Q         = qo_q;
    assign bus.R         = ro_q;
    assign bus.dz        = dz_q;

endmodule
